xibus_target: RTL and testbench

- Bus-side responder for the XiBus multiplexed address/data interface. It is the counterpart of the CPU-side encoder.
- Samples the address cycle and decodes tm1n/tm0n plus AD[1:0] back into a read/write command with byte enables.
- Captures write data, runs a req/ack handshake to a local register/memory port, and returns read data with a one-cycle ready/error response.

---
 rtl/xibus_pkg.sv | 35 +++
 rtl/xibus_tm_decoder.sv | 52 +++++
 rtl/xibus_target.sv | 170 +++++++++++++++++
 tb/tb_xibus_target.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xibus_pkg.sv
// XiBus target shared definitions: transfer-mode/AD encodings, byte enables, FSM states.
package xibus_pkg;

    // {tm1n, tm0n} transfer modes (active-low bits as seen on the bus)
    localparam logic [1:0] TM_READ  = 2'b11;
    localparam logic [1:0] TM_WBYTE = 2'b00;
    localparam logic [1:0] TM_WWIDE = 2'b01;

    // AD[1:0] sub-codes for byte writes
    localparam logic [1:0] AD_BYTE0 = 2'b00;
    localparam logic [1:0] AD_BYTE1 = 2'b10;
    localparam logic [1:0] AD_BYTE2 = 2'b01;
    localparam logic [1:0] AD_BYTE3 = 2'b11;

    // AD[1:0] sub-codes for word/half writes and reads
    localparam logic [1:0] AD_WORD  = 2'b00;
    localparam logic [1:0] AD_HALF0 = 2'b01;
    localparam logic [1:0] AD_HALF1 = 2'b11;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_REQ   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/xibus_tm_decoder.sv
// Combinational {tm1n,tm0n,ad[1:0]} -> {we, be, illegal}; inverse of the CPU-side encoder.
// Zero latency; no flow control. Illegal codes report we=0, be=0.
module xibus_tm_decoder
    import xibus_pkg::*;
(
    input  logic [1:0] tm,
    input  logic [1:0] ad_lo,
    output logic       we,
    output logic [3:0] be,
    output logic       illegal
);

    always_comb begin
        we      = 1'b0;
        be      = 4'b0000;
        illegal = 1'b1;
        case (tm)
            TM_READ: begin
                if (ad_lo == AD_WORD) begin
                    be      = BE_WORD;
                    illegal = 1'b0;
                end
            end
            TM_WBYTE: begin
                we      = 1'b1;
                illegal = 1'b0;
                case (ad_lo)
                    AD_BYTE0: be = BE_BYTE0;
                    AD_BYTE1: be = BE_BYTE1;
                    AD_BYTE2: be = BE_BYTE2;
                    default:  be = BE_BYTE3;
                endcase
            end
            TM_WWIDE: begin
                case (ad_lo)
                    AD_WORD: begin
                        we = 1'b1; be = BE_WORD; illegal = 1'b0;
                    end
                    AD_HALF0: begin
                        we = 1'b1; be = BE_HALF0; illegal = 1'b0;
                    end
                    AD_HALF1: begin
                        we = 1'b1; be = BE_HALF1; illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xibus_target.sv
// XiBus target: decodes the address cycle, runs a req/ack local access, returns a one-cycle rdy/err.
// Latency read T2 / write T3 / illegal T1 from bus_adrcy; loc_req held until loc_ack or TIMEOUT cycles.
module xibus_target
    import xibus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_adrcy,
    input  logic [31:0] bus_ad_i,
    input  logic        bus_tm1n,
    input  logic        bus_tm0n,
    output logic [31:0] bus_ad_o,
    output logic        bus_ad_oe,
    output logic        bus_rdy_o,
    output logic        bus_err_o,
    output logic        loc_req,
    output logic        loc_we,
    output logic [31:0] loc_addr,
    output logic [3:0]  loc_be,
    output logic [31:0] loc_wdata,
    input  logic        loc_ack,
    input  logic [31:0] loc_rdata
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        loc_req_q, loc_req_d;
    logic        loc_we_q, loc_we_d;
    logic [31:0] loc_addr_q, loc_addr_d;
    logic [3:0]  loc_be_q, loc_be_d;
    logic [31:0] loc_wdata_q, loc_wdata_d;
    logic [31:0] bus_ad_o_q, bus_ad_o_d;
    logic        bus_ad_oe_q, bus_ad_oe_d;
    logic        bus_rdy_q, bus_rdy_d;
    logic        bus_err_q, bus_err_d;

    logic        dec_we;
    logic [3:0]  dec_be;
    logic        dec_illegal;
    logic        hit;

    xibus_tm_decoder u_dec (
        .tm      ({bus_tm1n, bus_tm0n}),
        .ad_lo   (bus_ad_i[1:0]),
        .we      (dec_we),
        .be      (dec_be),
        .illegal (dec_illegal)
    );

    assign hit = bus_adrcy && ((bus_ad_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loc_req_d   = loc_req_q;
        loc_we_d    = loc_we_q;
        loc_addr_d  = loc_addr_q;
        loc_be_d    = loc_be_q;
        loc_wdata_d = loc_wdata_q;
        bus_ad_o_d  = bus_ad_o_q;
        bus_ad_oe_d = bus_ad_oe_q;
        bus_rdy_d   = bus_rdy_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    loc_addr_d = {bus_ad_i[31:2], 2'b00};
                    loc_be_d   = dec_be;
                    loc_we_d   = dec_we;
                    if (dec_illegal) begin
                        state_d   = ST_RESP;
                        bus_rdy_d = 1'b1;
                        bus_err_d = 1'b1;
                    end else if (dec_we) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d   = ST_REQ;
                        loc_req_d = 1'b1;
                        cnt_d     = 16'd0;
                    end
                end
            end
            ST_WDATA: begin
                loc_wdata_d = bus_ad_i;
                state_d     = ST_REQ;
                loc_req_d   = 1'b1;
                cnt_d       = 16'd0;
            end
            ST_REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (loc_ack) begin
                    state_d   = ST_RESP;
                    loc_req_d = 1'b0;
                    bus_rdy_d = 1'b1;
                    bus_err_d = 1'b0;
                    if (!loc_we_q) begin
                        bus_ad_o_d  = loc_rdata;
                        bus_ad_oe_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    loc_req_d = 1'b0;
                    bus_rdy_d = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                // RESP: outputs return to their idle-low values
                state_d     = ST_IDLE;
                cnt_d       = 16'd0;
                loc_we_d    = 1'b0;
                loc_addr_d  = 32'd0;
                loc_be_d    = 4'd0;
                loc_wdata_d = 32'd0;
                bus_ad_o_d  = 32'd0;
                bus_ad_oe_d = 1'b0;
                bus_rdy_d   = 1'b0;
                bus_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            loc_req_q   <= 1'b0;
            loc_we_q    <= 1'b0;
            loc_addr_q  <= 32'd0;
            loc_be_q    <= 4'd0;
            loc_wdata_q <= 32'd0;
            bus_ad_o_q  <= 32'd0;
            bus_ad_oe_q <= 1'b0;
            bus_rdy_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loc_req_q   <= loc_req_d;
            loc_we_q    <= loc_we_d;
            loc_addr_q  <= loc_addr_d;
            loc_be_q    <= loc_be_d;
            loc_wdata_q <= loc_wdata_d;
            bus_ad_o_q  <= bus_ad_o_d;
            bus_ad_oe_q <= bus_ad_oe_d;
            bus_rdy_q   <= bus_rdy_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign loc_req   = loc_req_q;
    assign loc_we    = loc_we_q;
    assign loc_addr  = loc_addr_q;
    assign loc_be    = loc_be_q;
    assign loc_wdata = loc_wdata_q;
    assign bus_ad_o  = bus_ad_o_q;
    assign bus_ad_oe = bus_ad_oe_q;
    assign bus_rdy_o = bus_rdy_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_xibus_target.sv
// Directed bench for xibus_target: reset, write/read paths, full code sweep, timeout, mask miss, reset abort.
module tb_xibus_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_adrcy;
    logic [31:0] bus_ad_i;
    logic        bus_tm1n;
    logic        bus_tm0n;
    logic [31:0] bus_ad_o;
    logic        bus_ad_oe;
    logic        bus_rdy_o;
    logic        bus_err_o;
    logic        loc_req;
    logic        loc_we;
    logic [31:0] loc_addr;
    logic [3:0]  loc_be;
    logic [31:0] loc_wdata;
    logic        loc_ack;
    logic [31:0] loc_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xibus_target #(
        .BASE_ADDR (32'h0000_0000),
        .ADDR_MASK (32'hFFFF_0000),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_adrcy (bus_adrcy),
        .bus_ad_i  (bus_ad_i),
        .bus_tm1n  (bus_tm1n),
        .bus_tm0n  (bus_tm0n),
        .bus_ad_o  (bus_ad_o),
        .bus_ad_oe (bus_ad_oe),
        .bus_rdy_o (bus_rdy_o),
        .bus_err_o (bus_err_o),
        .loc_req   (loc_req),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_be    (loc_be),
        .loc_wdata (loc_wdata),
        .loc_ack   (loc_ack),
        .loc_rdata (loc_rdata)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_cycle(input logic [1:0] tm, input logic [31:0] ad);
        bus_adrcy = 1'b1;
        bus_tm1n  = tm[1];
        bus_tm0n  = tm[0];
        bus_ad_i  = ad;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_adrcy = 1'b0; bus_ad_i = '0; bus_tm1n = 1'b1; bus_tm0n = 1'b1;
        loc_ack = 1'b0; loc_rdata = '0;
        step(); step();
        checks++;
        if ({loc_req, loc_we, bus_rdy_o, bus_err_o, bus_ad_oe} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {loc_req, loc_we, bus_rdy_o, bus_err_o, bus_ad_oe});
        end
        checks++;
        if ({loc_addr, loc_be, loc_wdata, bus_ad_o} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: addr %h be %b wdata %h ad_o %h want all 0", loc_addr, loc_be, loc_wdata, bus_ad_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_byte1();
        addr_cycle(2'b00, 32'h0000_1236);               // T0
        step();                                          // T1: data phase
        bus_adrcy = 1'b0; bus_ad_i = 32'hAABB_CCDD;
        checks++;
        if (loc_req !== 1'b0 || bus_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_t1: req %b rdy %b want 0 0", loc_req, bus_rdy_o);
        end
        step();                                          // T2: REQ
        bus_ad_i = 32'h0;
        checks++;
        if ({loc_req, loc_we, loc_be, loc_addr, loc_wdata} !== {1'b1, 1'b1, 4'b0010, 32'h0000_1234, 32'hAABB_CCDD}) begin
            errors++;
            $display("FAIL wr_req: req %b we %b be %b addr %h wdata %h want 1 1 0010 00001234 aabbccdd",
                     loc_req, loc_we, loc_be, loc_addr, loc_wdata);
        end
        loc_ack = 1'b1;
        step();                                          // T3
        loc_ack = 1'b0;
        checks++;
        if ({bus_rdy_o, bus_err_o, bus_ad_oe, loc_req} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_rdy: rdy/err/oe/req %b want 1000", {bus_rdy_o, bus_err_o, bus_ad_oe, loc_req});
        end
        step();
        checks++;
        if (bus_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_rdy_pulse: rdy %b want 0", bus_rdy_o);
        end
    endtask

    task automatic test_read_wait3();
        int req_cycles = 0;
        addr_cycle(2'b11, 32'h0000_0040);
        step();                                          // T1
        bus_adrcy = 1'b0;
        if (loc_req) req_cycles++;
        step();                                          // T2
        if (loc_req) req_cycles++;
        step();                                          // T3: ack here
        if (loc_req) req_cycles++;
        checks++;
        if ({loc_we, loc_be, loc_addr} !== {1'b0, 4'b1111, 32'h0000_0040}) begin
            errors++;
            $display("FAIL rd_cmd: we %b be %b addr %h want 0 1111 00000040", loc_we, loc_be, loc_addr);
        end
        loc_ack = 1'b1; loc_rdata = 32'h1234_5678;
        step();                                          // T4
        loc_ack = 1'b0; loc_rdata = 32'h0;
        if (loc_req) req_cycles++;
        checks++;
        if (req_cycles !== 3) begin
            errors++;
            $display("FAIL rd_req_len: got %0d want 3", req_cycles);
        end
        checks++;
        if ({bus_rdy_o, bus_err_o, bus_ad_oe, bus_ad_o} !== {3'b101, 32'h1234_5678}) begin
            errors++;
            $display("FAIL rd_resp: rdy %b err %b oe %b ad_o %h want 1 0 1 12345678", bus_rdy_o, bus_err_o, bus_ad_oe, bus_ad_o);
        end
        step();
        checks++;
        if ({bus_rdy_o, bus_ad_oe, bus_ad_o} !== 34'd0) begin
            errors++;
            $display("FAIL rd_after: rdy %b oe %b ad_o %h want 0 0 0", bus_rdy_o, bus_ad_oe, bus_ad_o);
        end
    endtask

    task automatic test_code_sweep();
        for (int c = 0; c < 16; c++) begin
            logic [3:0] code;
            logic       exp_ill;
            logic       exp_we;
            logic [3:0] exp_be;
            code = 4'(c);
            exp_ill = 1'b0; exp_we = 1'b1; exp_be = 4'b0000;
            case (code)
                4'b0000: exp_be = 4'b0001;
                4'b0010: exp_be = 4'b0010;
                4'b0001: exp_be = 4'b0100;
                4'b0011: exp_be = 4'b1000;
                4'b0100: exp_be = 4'b1111;
                4'b0101: exp_be = 4'b0011;
                4'b0111: exp_be = 4'b1100;
                4'b1100: begin exp_be = 4'b1111; exp_we = 1'b0; end
                default: begin exp_ill = 1'b1; exp_we = 1'b0; end
            endcase
            addr_cycle(code[3:2], {30'h0000_0040, code[1:0]});
            step();                                      // T1
            bus_adrcy = 1'b0; bus_ad_i = 32'h5A5A_0000 | 32'(c);
            if (exp_ill) begin
                checks++;
                if ({bus_rdy_o, bus_err_o, loc_req, bus_ad_oe} !== 4'b1100) begin
                    errors++;
                    $display("FAIL sweep_ill code=%b: rdy/err/req/oe %b want 1100", code, {bus_rdy_o, bus_err_o, loc_req, bus_ad_oe});
                end
                step();
                checks++;
                if ({bus_rdy_o, loc_req} !== 2'b00) begin
                    errors++;
                    $display("FAIL sweep_ill_after code=%b: rdy/req %b want 00", code, {bus_rdy_o, loc_req});
                end
            end else begin
                if (exp_we) step();                      // writes spend T1 in the data phase
                checks++;
                if ({loc_req, loc_we, loc_be} !== {1'b1, exp_we, exp_be}) begin
                    errors++;
                    $display("FAIL sweep_cmd code=%b: req %b we %b be %b want 1 %b %b", code, loc_req, loc_we, loc_be, exp_we, exp_be);
                end
                loc_ack = 1'b1;
                step();
                loc_ack = 1'b0;
                checks++;
                if ({bus_rdy_o, bus_err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL sweep_rdy code=%b: rdy/err %b want 10", code, {bus_rdy_o, bus_err_o});
                end
                step();
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        bit done = 0;
        addr_cycle(2'b11, 32'h0000_0100);
        step();
        bus_adrcy = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus_rdy_o) done = 1;
            else begin
                if (loc_req) req_cycles++;
                step();
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL to_bound: no rdy within 40 cycles, got 0 want 1");
        end
        checks++;
        if (req_cycles !== 16) begin
            errors++;
            $display("FAIL to_req_len: got %0d want 16", req_cycles);
        end
        checks++;
        if ({bus_rdy_o, bus_err_o, bus_ad_oe, loc_req} !== 4'b1100) begin
            errors++;
            $display("FAIL to_resp: rdy/err/oe/req %b want 1100", {bus_rdy_o, bus_err_o, bus_ad_oe, loc_req});
        end
        step();
    endtask

    task automatic test_back_to_back();
        addr_cycle(2'b11, 32'h0001_0000);                // mask miss
        step();
        bus_adrcy = 1'b0;
        step();
        checks++;
        if ({loc_req, bus_rdy_o} !== 2'b00) begin
            errors++;
            $display("FAIL miss: req/rdy %b want 00", {loc_req, bus_rdy_o});
        end
        addr_cycle(2'b11, 32'h0000_0080);
        step();                                          // T1: REQ
        addr_cycle(2'b00, 32'h0000_0200);                // ignored adrcy
        step();                                          // T2: still REQ
        bus_adrcy = 1'b0;
        checks++;
        if ({loc_req, loc_we, loc_addr} !== {2'b10, 32'h0000_0080}) begin
            errors++;
            $display("FAIL busy_ign: req %b we %b addr %h want 1 0 00000080", loc_req, loc_we, loc_addr);
        end
        loc_ack = 1'b1; loc_rdata = 32'hCAFE_F00D;
        step();
        loc_ack = 1'b0; loc_rdata = 32'h0;
        checks++;
        if ({bus_rdy_o, bus_ad_oe, bus_ad_o} !== {2'b11, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL busy_resp: rdy %b oe %b ad_o %h want 1 1 cafef00d", bus_rdy_o, bus_ad_oe, bus_ad_o);
        end
        step();
        step();
        checks++;
        if ({loc_req, bus_rdy_o} !== 2'b00) begin
            errors++;
            $display("FAIL busy_nostart: req/rdy %b want 00", {loc_req, bus_rdy_o});
        end
    endtask

    task automatic test_reset_abort();
        addr_cycle(2'b11, 32'h0000_0300);
        step();
        bus_adrcy = 1'b0;
        checks++;
        if (loc_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: req %b want 1", loc_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({loc_req, loc_we, bus_rdy_o, bus_err_o, bus_ad_oe, loc_addr, loc_be} !== 41'd0) begin
            errors++;
            $display("FAIL abort_clear: req %b rdy %b addr %h be %b want all 0", loc_req, bus_rdy_o, loc_addr, loc_be);
        end
        step();
        checks++;
        if ({loc_req, bus_rdy_o} !== 2'b00) begin
            errors++;
            $display("FAIL abort_norsp: req/rdy %b want 00", {loc_req, bus_rdy_o});
        end
        addr_cycle(2'b00, 32'h0000_0503);                // write byte3
        step();
        bus_adrcy = 1'b0; bus_ad_i = 32'h1100_0000;
        step();
        bus_ad_i = 32'h0;
        checks++;
        if ({loc_req, loc_we, loc_be, loc_addr, loc_wdata} !== {2'b11, 4'b1000, 32'h0000_0500, 32'h1100_0000}) begin
            errors++;
            $display("FAIL abort_wr: req %b we %b be %b addr %h wdata %h want 1 1 1000 00000500 11000000",
                     loc_req, loc_we, loc_be, loc_addr, loc_wdata);
        end
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        checks++;
        if ({bus_rdy_o, bus_err_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_wr_rdy: rdy/err %b want 10", {bus_rdy_o, bus_err_o});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_byte1();
        test_read_wait3();
        test_code_sweep();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
